// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage registers.
package pipe_pkg;

   // Occupancy state of a skid stage; the encoding doubles as the entry count.
   typedef enum logic [1:0] {
      PIPE_EMPTY = 2'd0,
      PIPE_ONE   = 2'd1,
      PIPE_TWO   = 2'd2
   } pipe_state_t;

   // MEM/WB payload: wreg, m2reg, mo[31:0], alu[31:0], rn[4:0].
   localparam int PIPE_MEMWB_W = 71;

endpackage

// File: rtl/pipe_data_reg.sv
// Load-enabled payload register with asynchronous active-low clear to zero.
module pipe_data_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clrn,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;

   // Capture the payload when enabled; clear on reset.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) data_q <= '0;
      else if (en_i) data_q <= d_i;
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid
// buffer. in_ready is decoded from the state register only, so there is no
// combinational path from out_ready to in_ready.
// Optional feature macro: PIPE_FLUSH_EN adds a synchronous flush input.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_MEMWB_W
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
`ifdef PIPE_FLUSH_EN
   input  logic              flush,
`endif
   output logic [1:0]        occupancy
);

   pipe_state_t       state_q, state_d;
   logic              in_fire, out_fire;
   logic              m_ld, s_ld, m_from_s;
   logic [DATA_W-1:0] m_d, m_q, s_q;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign m_d      = m_from_s ? s_q : in_data;

   pipe_data_reg #(.W(DATA_W)) u_main (
      .clk  (clk),
      .clrn (clrn),
      .en_i (m_ld),
      .d_i  (m_d),
      .q_o  (m_q)
   );

   pipe_data_reg #(.W(DATA_W)) u_skid (
      .clk  (clk),
      .clrn (clrn),
      .en_i (s_ld),
      .d_i  (in_data),
      .q_o  (s_q)
   );

   // State register; reset discards all held entries immediately.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state_q <= PIPE_EMPTY;
      else       state_q <= state_d;
   end

   // Next state and data-register load enables; encoding 3 behaves as EMPTY.
   always_comb begin
      state_d  = state_q;
      m_ld     = 1'b0;
      s_ld     = 1'b0;
      m_from_s = 1'b0;
      case (state_q)
         PIPE_ONE: begin
            if (in_fire && out_fire) begin
               m_ld = 1'b1;
            end else if (in_fire) begin
               s_ld    = 1'b1;
               state_d = PIPE_TWO;
            end else if (out_fire) begin
               state_d = PIPE_EMPTY;
            end
         end
         PIPE_TWO: begin
            if (out_fire) begin
               m_ld     = 1'b1;
               m_from_s = 1'b1;
               state_d  = PIPE_ONE;
            end
         end
         default: begin
            if (in_fire) begin
               m_ld    = 1'b1;
               state_d = PIPE_ONE;
            end else begin
               state_d = PIPE_EMPTY;
            end
         end
      endcase
`ifdef PIPE_FLUSH_EN
      // Flush wins over everything; an offered payload is dropped.
      if (flush) begin
         state_d = PIPE_EMPTY;
         m_ld    = 1'b0;
         s_ld    = 1'b0;
      end
`endif
   end

   // Output decode from the state register only.
   always_comb begin
      out_valid = 1'b0;
      in_ready  = 1'b1;
      occupancy = 2'd0;
      case (state_q)
         PIPE_ONE: begin
            out_valid = 1'b1;
            occupancy = 2'd1;
         end
         PIPE_TWO: begin
            out_valid = 1'b1;
            in_ready  = 1'b0;
            occupancy = 2'd2;
         end
         default: ;
      endcase
   end

   assign out_data = m_q;

endmodule
